// File: rtl/usbfs_endp_tx_pkg.sv
// usbfs_endp_tx_pkg
// Shared types and sizing helpers for the USB full-speed endpoint blocks.
//   endp_tx_state_e : IN-endpoint adapter FSM states
//   nbytes_w()      : width needed to hold a packet length 0..max_pkt
//   idx_w()         : width of a byte index 0..max_pkt-1
package usbfs_endp_tx_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2
  } endp_tx_state_e;

  function automatic int nbytes_w(input int max_pkt);
    return $clog2(max_pkt + 1);
  endfunction

  function automatic int idx_w(input int max_pkt);
    return $clog2(max_pkt);
  endfunction

endpackage

// File: rtl/usbfs_endp_tx_fifo.sv
// usbfs_endp_tx_fifo
// Generic synchronous FIFO with first-word-fall-through read data.
//   clk, rst_n : clock, asynchronous active-low reset (control state only)
//   push/wdata : write side; a push while full is ignored
//   pop/rdata  : read side; rdata is the current head, pop while empty ignored
//   count      : number of stored entries (0..DEPTH)
//   full       : count == DEPTH
// FLOPS_NOT_MEM=1 builds the storage from resettable flops, otherwise a plain
// memory array that a synthesis tool may map to RAM.
module usbfs_endp_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter bit FLOPS_NOT_MEM = 1'b0,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  generate
    if (FLOPS_NOT_MEM) begin : g_flops
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
          mem[wr_ptr] <= wdata;
        end
      end
    end else begin : g_mem
      always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
      end
    end
  endgenerate

endmodule

// File: rtl/usbfs_endp_tx.sv
// usbfs_endp_tx
// Device-to-host (IN) endpoint adapter. Buffers an upstream byte stream in a
// MAX_PKT-deep FIFO, frames it into full packets or short packets after an
// idle timeout, copies each packet into the transactor buffer and holds it
// armed until the transactor reports delivery.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_valid, i_data  : upstream byte stream; o_ready = FIFO not full
//   o_etValid        : packet armed in the transactor buffer
//   i_etReady        : transactor delivered the packet (host ACK)
//   o_etStall        : endpoint halt, never asserted
//   o_etWrEn/Idx/Byte: byte write strobe into the transactor buffer
//   o_etWrNBytes     : packet length, stable while o_etValid=1
module usbfs_endp_tx
  import usbfs_endp_tx_pkg::*;
#(
  parameter int MAX_PKT      = 8,
  parameter int FLUSH_CYCLES = 1024,
  localparam int NBYTES_W = nbytes_w(MAX_PKT),
  localparam int IDX_W    = idx_w(MAX_PKT),
  localparam int FLUSH_W  = $clog2(FLUSH_CYCLES)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  input  logic [7:0]          i_data,
  output logic                o_ready,
  output logic                o_etValid,
  input  logic                i_etReady,
  output logic                o_etStall,
  output logic                o_etWrEn,
  output logic [IDX_W-1:0]    o_etWrIdx,
  output logic [7:0]          o_etWrByte,
  output logic [NBYTES_W-1:0] o_etWrNBytes
);

  endp_tx_state_e      state;
  endp_tx_state_e      state_nxt;
  logic [FLUSH_W-1:0]  flush_cnt;
  logic [NBYTES_W-1:0] wr_idx;
  logic [NBYTES_W-1:0] nbytes;
  logic [NBYTES_W-1:0] fifo_count;
  logic                fifo_full;
  logic                push;
  logic                wr_en;
  logic                load_start;
  logic                full_pkt;
  logic                flush_due;

  usbfs_endp_tx_fifo #(
    .WIDTH        (8),
    .DEPTH        (MAX_PKT),
    .FLOPS_NOT_MEM(1'b0)
  ) u_fifo (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .push (i_valid),
    .wdata(i_data),
    .pop  (wr_en),
    .rdata(o_etWrByte),
    .count(fifo_count),
    .full (fifo_full)
  );

  assign o_ready   = !fifo_full;
  assign push      = i_valid && o_ready;
  assign full_pkt  = (fifo_count == NBYTES_W'(MAX_PKT));
  // Short packets only when something is buffered: never a zero-length packet.
  assign flush_due = (fifo_count != '0) && (flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1));

  always_comb begin
    state_nxt  = state;
    wr_en      = 1'b0;
    load_start = 1'b0;
    unique case (state)
      ST_FILL: begin
        if (full_pkt || flush_due) begin
          state_nxt  = ST_LOAD;
          load_start = 1'b1;
        end
      end
      ST_LOAD: begin
        // One cycle after the last write the index equals the length.
        if (wr_idx == nbytes) state_nxt = ST_ARMED;
        else                  wr_en     = 1'b1;
      end
      ST_ARMED: begin
        if (i_etReady) state_nxt = ST_FILL;
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_FILL;
      flush_cnt <= '0;
      wr_idx    <= '0;
      nbytes    <= '0;
    end else begin
      state <= state_nxt;

      if (push || (state != ST_FILL) || (fifo_count == '0))
        flush_cnt <= '0;
      else if (flush_cnt != FLUSH_W'(FLUSH_CYCLES - 1))
        flush_cnt <= flush_cnt + FLUSH_W'(1);

      // Snapshot uses the pre-push count; a same-cycle push joins the next packet.
      if (load_start) begin
        nbytes <= fifo_count;
        wr_idx <= '0;
      end else if (wr_en) begin
        wr_idx <= wr_idx + NBYTES_W'(1);
      end
    end
  end

  assign o_etValid    = (state == ST_ARMED);
  assign o_etStall    = 1'b0;
  assign o_etWrEn     = wr_en;
  assign o_etWrIdx    = wr_idx[IDX_W-1:0];
  assign o_etWrNBytes = nbytes;

endmodule

// File: tb/tb_usbfs_endp_tx.sv
// tb_usbfs_endp_tx
// Randomized and directed stimulus for usbfs_endp_tx (MAX_PKT=8,
// FLUSH_CYCLES=16), checked every cycle against a queue-based packet model.
module tb_usbfs_endp_tx;

  localparam int MAX_PKT = 8;
  localparam int FLUSH   = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       et_ready = 1'b0;
  logic       ready;
  logic       et_valid;
  logic       et_stall;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic [7:0] wr_byte;
  logic [3:0] wr_nbytes;

  usbfs_endp_tx #(
    .MAX_PKT     (MAX_PKT),
    .FLUSH_CYCLES(FLUSH)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (valid),
    .i_data      (data),
    .o_ready     (ready),
    .o_etValid   (et_valid),
    .i_etReady   (et_ready),
    .o_etStall   (et_stall),
    .o_etWrEn    (wr_en),
    .o_etWrIdx   (wr_idx),
    .o_etWrByte  (wr_byte),
    .o_etWrNBytes(wr_nbytes)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: buffered bytes, phase (0 fill, 1 load, 2 armed),
  // packet length, bytes written so far, idle cycles with data pending.
  byte unsigned q[$];
  int phase = 0;
  int nb    = 0;
  int idx   = 0;
  int idle  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    phase = 0;
    nb    = 0;
    idx   = 0;
    idle  = 0;
  endtask

  task automatic model_update(input bit v, input logic [7:0] d, input bit r);
    bit push;
    int sz;
    int ph;
    byte unsigned dummy;
    sz   = q.size();
    ph   = phase;
    push = v && (sz < MAX_PKT);
    case (ph)
      0: if (sz == MAX_PKT || (sz > 0 && idle == FLUSH - 1)) begin
           phase = 1;
           nb    = sz;
           idx   = 0;
         end
      1: if (idx == nb) phase = 2;
         else begin
           dummy = q.pop_front();
           idx++;
         end
      default: if (r) phase = 0;
    endcase
    if (push || ph != 0 || sz == 0) idle = 0;
    else if (idle < FLUSH - 1)      idle++;
    if (push) q.push_back(d);
  endtask

  task automatic compare();
    bit exp_wr;
    exp_wr = (phase == 1) && (idx < nb);
    chk("ready",   ready,     (q.size() < MAX_PKT));
    chk("valid",   et_valid,  (phase == 2));
    chk("stall",   et_stall,  0);
    chk("wr_en",   wr_en,     exp_wr);
    chk("nbytes",  wr_nbytes, nb);
    if (exp_wr) begin
      chk("wr_idx",  wr_idx,  idx);
      chk("wr_byte", wr_byte, q[0]);
    end
  endtask

  // Called at a negedge: drive inputs, advance one clock, check outputs.
  task automatic step(input bit v, input logic [7:0] d, input bit r);
    valid    = v;
    data     = d;
    et_ready = r;
    @(posedge clk);
    model_update(v, d, r);
    @(negedge clk);
    compare();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (phase != 2 && n < 60) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    if (phase != 2) chk("arm_timeout", et_valid, 1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int lat;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    compare();
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0);

    // Full packet 0x00..0x07 and LOAD-to-valid latency
    for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 1'b0);
    lat = 0;
    while (!wr_en && lat < 10) begin
      step(1'b0, 8'h00, 1'b0);
      lat++;
    end
    lat = 0;
    while (!et_valid && lat < 30) begin
      step(1'b0, 8'h00, 1'b0);
      lat++;
    end
    chk("load_to_valid", lat, 9);
    chk("full_nbytes", wr_nbytes, 8);
    step(1'b0, 8'h00, 1'b1);
    chk("valid_drop", et_valid, 0);

    // Short packet after idle timeout
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hA2, 1'b0);
    step(1'b1, 8'hA3, 1'b0);
    lat = 0;
    while (!wr_en && lat < 40) begin
      step(1'b0, 8'h00, 1'b0);
      lat++;
    end
    chk("flush_wait", lat, 16);
    chk("flush_nbytes", wr_nbytes, 3);
    drain();

    // Armed hold with upstream filling the FIFO
    for (int i = 0; i < 8; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
    lat = 0;
    while (phase != 2 && lat < 30) begin
      step(1'b0, 8'h00, 1'b0);
      lat++;
    end
    for (int i = 0; i < 500; i++) step(i < 8, 8'h20 + 8'(i), 1'b0);
    chk("hold_ready", ready, 0);
    chk("hold_nbytes", wr_nbytes, 8);
    step(1'b0, 8'h00, 1'b1);
    drain();

    // Push on the flush trigger cycle
    step(1'b1, 8'h31, 1'b0);
    step(1'b1, 8'h32, 1'b0);
    lat = 0;
    while (!(phase == 0 && idle == FLUSH - 1) && lat < 40) begin
      step(1'b0, 8'h00, 1'b0);
      lat++;
    end
    step(1'b1, 8'h5A, 1'b0);
    chk("trig_nbytes", wr_nbytes, 2);
    drain();
    drain();

    // Asynchronous reset in the middle of LOAD
    for (int i = 0; i < 8; i++) step(1'b1, 8'h40 + 8'(i), 1'b0);
    lat = 0;
    while (!(phase == 1 && idx == 4) && lat < 30) begin
      step(1'b0, 8'h00, 1'b0);
      lat++;
    end
    chk("mid_load_idx", wr_idx, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wr_en",  wr_en,     0);
    chk("rst_valid",  et_valid,  0);
    chk("rst_nbytes", wr_nbytes, 0);
    chk("rst_ready",  ready,     1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    compare();
    for (int i = 0; i < 8; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
    drain();

    // Long idle with an empty FIFO: no zero-length packet
    for (int i = 0; i < 5 * FLUSH; i++) step(1'b0, 8'h00, 1'b0);

    // Randomized traffic with alternating dense and sparse phases
    for (int i = 0; i < 4000; i++) begin
      bit v;
      bit r;
      if ((i / 400) % 2 == 0) v = ($urandom_range(0, 3) != 0);
      else                    v = ($urandom_range(0, 24) == 0);
      r = ($urandom_range(0, 5) == 0);
      step(v, 8'($urandom), r);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
